// File: rtl/mont_domain_enter.sv
// -----------------------------------------------------------------------------
// mont_domain_enter
//   Moves an operand into the Montgomery domain ahead of mod_exponent.
//   For a base a and an odd modulus N it produces
//       base_out          = (a * 2^WIDTH) mod N
//       start_product_out =  2^WIDTH      mod N
//   Both values come from WIDTH rounds of modular doubling, one round per
//   cycle, with the two accumulators updated in parallel.
//
// Ports
//   clk_in             in   1      system clock, rising edge
//   rst_in             in   1      asynchronous reset, active high
//   base               in   WIDTH  operand a (must be < modulo)
//   modulo             in   WIDTH  modulus N (must be odd and >= 3)
//   valid_in           in   1      request strobe, only sampled in IDLE
//   base_out           out  WIDTH  a*R mod N, held until the next job completes
//   start_product_out  out  WIDTH  R mod N, held until the next job completes
//   valid_out          out  1      one-cycle completion pulse
//   error_out          out  1      set with valid_out when operands were bad
//   busy_out           out  1      high while a job is in RUN or DONE
// -----------------------------------------------------------------------------
module mont_domain_enter #(
    parameter int WIDTH = 512
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] modulo,
    input  logic             valid_in,
    output logic [WIDTH-1:0] base_out,
    output logic [WIDTH-1:0] start_product_out,
    output logic             valid_out,
    output logic             error_out,
    output logic             busy_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One modular doubling step. The shifted value is kept at WIDTH+1 bits so
    // the compare/subtract is exact even for N = 2^WIDTH-1; since acc < N the
    // doubled value is < 2N and one conditional subtract is sufficient.
    function automatic logic [WIDTH-1:0] mod_double(input logic [WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0] n);
        logic [WIDTH:0] t;
        logic [WIDTH:0] nw;
        t  = {acc, 1'b0};
        nw = {1'b0, n};
        t  = (t >= nw) ? (t - nw) : t;
        return t[WIDTH-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] acc_a_q, acc_a_d;
    logic [WIDTH-1:0] acc_1_q, acc_1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] base_out_q, base_out_d;
    logic [WIDTH-1:0] sp_out_q, sp_out_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] dbl_a_s;
    logic [WIDTH-1:0] dbl_1_s;
    logic             operand_bad_s;

    // Next-state and output logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        acc_a_d    = acc_a_q;
        acc_1_d    = acc_1_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        base_out_d = base_out_q;
        sp_out_d   = sp_out_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        dbl_a_s       = mod_double(acc_a_q, n_q);
        dbl_1_s       = mod_double(acc_1_q, n_q);
        operand_bad_s = ~modulo[0] | (modulo < WIDTH'(2'd3)) | (base >= modulo);

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    n_d = modulo;
                    if (operand_bad_s) begin
                        base_out_d = '0;
                        sp_out_d   = '0;
                        err_d      = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        acc_a_d = base;
                        acc_1_d = WIDTH'(1'b1);
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_a_d = dbl_a_s;
                acc_1_d = dbl_1_s;
                cnt_d   = cnt_q + CW'(1'b1);
                if (cnt_q == CNT_LAST) begin
                    // Last round: publish this round's results directly.
                    base_out_d = dbl_a_s;
                    sp_out_d   = dbl_1_s;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                error_d = err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers; reset aborts any job in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            acc_a_q    <= '0;
            acc_1_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            base_out_q <= '0;
            sp_out_q   <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            acc_a_q    <= acc_a_d;
            acc_1_q    <= acc_1_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            base_out_q <= base_out_d;
            sp_out_q   <= sp_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    assign base_out          = base_out_q;
    assign start_product_out = sp_out_q;
    assign valid_out         = valid_q;
    assign error_out         = error_q;
    assign busy_out          = busy_q;

endmodule
